// File: rtl/fetch_rv.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_rv
//  Description : Instruction fetch stage. Issues one instruction-memory read
//                at a time, buffers returned words with their addresses in a
//                small FIFO, and presents the head entry to the ALU stage.
//                A branch redirect flushes the buffer and drops any
//                outstanding response.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_rv #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] instruction,
    output logic        enable,
    output logic [31:0] pc
);

    // Depth is either 2 or 4, so one or two pointer bits suffice.
    localparam int PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   wptr_q,     wptr_d;
    logic [PTR_W-1:0]   rptr_q,     rptr_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic [31:0]        instr_q [FIFO_DEPTH];
    logic [31:0]        instr_d [FIFO_DEPTH];
    logic [31:0]        pcbuf_q [FIFO_DEPTH];
    logic [31:0]        pcbuf_d [FIFO_DEPTH];

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_target;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Request, buffer handshakes and head-of-buffer outputs.
    always_comb begin
        w_target    = branch_target & 32'hFFFF_FFFC;
        enable      = (count_q != '0);
        instruction = enable ? instr_q[rptr_q] : 32'h0;
        pc          = enable ? pcbuf_q[rptr_q] : 32'h0;
        imem_addr   = fetch_pc_q;
        // A redirect suppresses the request so the stale address never goes out.
        imem_req    = (state_q == S_FETCH) && (count_q < CNT_W'(FIFO_DEPTH)) && !branch_taken;
        w_accept    = imem_req && imem_ready;
        w_push      = (state_q == S_WAIT) && imem_rvalid && !branch_taken;
        w_pop       = enable && !stall && !branch_taken;
    end

    // Next-state computation for the FSM, fetch address and buffer.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        instr_d    = instr_q;
        pcbuf_d    = pcbuf_q;

        if (w_push) begin
            instr_d[wptr_q] = imem_rdata;
            pcbuf_d[wptr_q] = fetch_pc_q;
            wptr_d          = ptr_inc(wptr_q);
            fetch_pc_d      = fetch_pc_q + 32'd4;
        end
        if (w_pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Redirect wins over push, pop and stall.
        if (branch_taken) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            fetch_pc_d = w_target;
        end

        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (w_accept) state_d = branch_taken ? S_DRAIN : S_WAIT;
            // A redirect coinciding with the response consumes it, so no drain is needed.
            S_WAIT:  if (imem_rvalid) state_d = S_FETCH;
                     else if (branch_taken) state_d = S_DRAIN;
            S_DRAIN: if (imem_rvalid) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any outstanding request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_q[i] <= 32'h0;
                pcbuf_q[i] <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            pcbuf_q    <= pcbuf_d;
        end
    end

endmodule
`default_nettype wire
